imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
Arbitrates one single-port synchronous block RAM (1-cycle read latency, word-addressed, 32-bit) between the instruction-fetch requester and the load/store requester. Converts byte addresses to word addresses, issues at most one RAM access per cycle and routes returned read data to its owner. Data has fixed priority over fetch, with a starvation guard so fetch always progresses. Sits between the fetch/memory stages and the shared RAM instance.

Parameters:
AW, 10, RAM word-address width; mem_addr = byte_addr[AW+1:2]
STARVE_MAX, 3, consecutive denied fetch cycles after which fetch takes priority; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  combinational; request accepted this cycle
if_rvalid  out  1  registered; if_rdata valid, exactly 1 cycle after if_gnt
if_rdata  out  32  fetch read data
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_gnt  out  1  combinational; request accepted this cycle
d_rvalid  out  1  registered; d_rdata/d_err valid, 1 cycle after a read or misaligned grant
d_rdata  out  32  data read data
d_err  out  1  qualified by d_rvalid; misaligned access flag
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM word address
mem_din  out  32  RAM write data
mem_dout  in  32  RAM read data, valid 1 cycle after address

Behaviour:
- Grant (combinational, one per cycle):
  - Starvation guard: if starve_cnt == STARVE_MAX and if_req, grant fetch.
  - Otherwise d_req wins; fetch is granted only when d_req = 0.
  - if_gnt and d_gnt are never both 1.
- RAM drive:
  - mem_addr = granted requester's addr[AW+1:2]; upper address bits are ignored and wrap.
  - mem_we = d_gnt & d_we & aligned.
  - mem_din = d_wdata.
  - With no grant: mem_we = 0, mem_addr = 0.
- Misaligned data access (d_addr[1:0] != 0): still granted, RAM write suppressed. Next cycle d_rvalid = 1, d_err = 1, d_rdata = 0 (for reads and writes). Fetch addr[1:0] are ignored; fetch never errors.
- Owner register {NONE, IF, D_RD, D_ERR} records the access issued this cycle:
  - IF → if_rvalid = 1, if_rdata = mem_dout next cycle.
  - D_RD → d_rvalid = 1, d_rdata = mem_dout, d_err = 0 next cycle.
  - D_ERR → d_rvalid = 1, d_err = 1, d_rdata = 0 next cycle.
  - Aligned writes and idle cycles → NONE; no rvalid.
- Back-to-back: a new grant is allowed in the same cycle the previous read returns. Throughput is 1 access per cycle; read data is never lost.
- rdata outputs hold their last value while rvalid = 0.
- Starvation counter (4-bit):
  - +1 each cycle if_req = 1 and if_gnt = 0, saturating at STARVE_MAX.
  - Cleared on if_gnt or when if_req = 0.
- Reset (async assert, sync deassert by design): all outputs 0, owner = NONE, starve_cnt = 0. A read in flight at reset is dropped; no rvalid after release. Grants are possible in the first cycle after release.

Test Plan:
- Fetch stream: if_req = 1 with if_addr 0x0, 0x4, 0x8 on consecutive cycles, RAM preloaded word[n] = 0x1000+n → if_gnt = 1 each cycle; if_rvalid = 1 with 0x1000, 0x1001, 0x1002 on the following cycles, zero bubbles.
- Write/read: d_we = 1, d_addr = 0x10, d_wdata = 0xDEADBEEF, then d_we = 0 read of 0x10 → mem_we pulses once with mem_addr = 4; the read returns d_rvalid = 1, d_rdata = 0xDEADBEEF one cycle after grant.
- Collision and starvation: if_req and d_req both held high for 8 cycles, STARVE_MAX = 3 → d_gnt for 3 cycles, then if_gnt for 1, repeating. if_gnt is never denied more than 3 consecutive cycles; the two grants are never simultaneous.
- Misaligned: d_we = 1, d_addr = 0x13 → d_gnt = 1, mem_we = 0; next cycle d_rvalid = 1, d_err = 1, d_rdata = 0, RAM contents unchanged.
- Wrap: if_addr = 0x0000_1004 with AW = 10 → mem_addr = 1; returns word[1].
- Reset mid-read: assert rst_n = 0 in the cycle after a d read grant → d_rvalid stays 0 through and after reset. The first request after release is granted immediately, and starve_cnt restarts from 0.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
// Data wins by default; a starvation counter forces fetch through periodically.
module imem_dmem_arbiter #(
    parameter int AW         = 10,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    input  logic [31:0]   mem_dout
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DRD,
        OWN_DERR
    } owner_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    owner_e      owner_q, owner_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] if_hold_q, d_hold_q;
    logic        d_aligned, starved;
    logic        unused_addr;

    assign unused_addr = ^{if_addr[31:AW+2], if_addr[1:0],
                           d_addr[31:AW+2]};

    assign d_aligned = (d_addr[1:0] == 2'b00);
    assign starved   = if_req && (starve_q == SMAX);

    // Fixed priority: starved fetch, then data, then fetch.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        priority case (1'b1)
            starved: if_gnt = 1'b1;
            d_req:   d_gnt  = 1'b1;
            if_req:  if_gnt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        if (if_gnt) begin
            mem_addr = if_addr[AW+1:2];
        end else if (d_gnt) begin
            mem_addr = d_addr[AW+1:2];
            mem_we   = d_we && d_aligned;
        end
    end

    assign mem_din = d_wdata;

    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt) begin
            owner_d = OWN_IF;
        end else if (d_gnt) begin
            if (!d_aligned)
                owner_d = OWN_DERR;
            else if (!d_we)
                owner_d = OWN_DRD;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!if_req || if_gnt)
            starve_d = 4'd0;
        else if (starve_q < SMAX)
            starve_d = starve_q + 4'd1;
    end

    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_DRD) || (owner_q == OWN_DERR);
    assign d_err     = (owner_q == OWN_DERR);

    // Read data passes straight from the RAM and is held once rvalid drops.
    always_comb begin
        if_rdata = if_hold_q;
        d_rdata  = d_hold_q;
        if (owner_q == OWN_IF)
            if_rdata = mem_dout;
        if (owner_q == OWN_DRD)
            d_rdata = mem_dout;
        if (owner_q == OWN_DERR)
            d_rdata = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_NONE;
            starve_q  <= 4'd0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            if_hold_q <= if_rdata;
            d_hold_q  <= d_rdata;
        end
    end

endmodule
